// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants, write-request record and helpers for the register file write arbiter.
// The age tag is a wrapping sequence number; the two live entries always differ by one.
package regfile_write_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int PC_IDX = 15;
  localparam int AGE_W  = 3;
  localparam int NREG   = 15;

  typedef struct packed {
    logic              valid;
    logic [AGE_W-1:0]  age;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  // Wrap-safe compare: a is older when (a - b) is negative in AGE_W bits.
  function automatic logic is_older(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
    logic [AGE_W-1:0] diff;
    diff = a - b;
    return diff[AGE_W-1];
  endfunction

  function automatic logic [NREG-1:0] reg_onehot(input logic [ADDR_W-1:0] addr);
    logic [NREG-1:0] mask;
    mask = '0;
    for (int i = 0; i < NREG; i++) begin
      if (addr == ADDR_W'(i)) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/regfile_wr_buffer.sv
// One-entry valid/ready holding register for a single writeback source.
module regfile_wr_buffer
  import regfile_write_arbiter_pkg::*;
(
  input  logic              CLK,
  input  logic              Reset,
  input  logic              in_valid,
  input  logic [AGE_W-1:0]  in_age,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              drain,
  output logic              ready,
  output logic              load,
  output wr_req_t           entry
);

  // The slot frees up in the same cycle it is granted, so a new request can land behind it.
  assign ready = Reset & (~entry.valid | drain);
  assign load  = in_valid & ready;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      entry <= '0;
    end else if (load) begin
      entry.valid <= 1'b1;
      entry.age   <= in_age;
      entry.addr  <= in_addr;
      entry.data  <= in_data;
    end else if (drain) begin
      entry.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between the ALU and load writeback sources,
// committing oldest-first one per cycle and diverting R15 writes to the PC strobe.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
(
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Req0Valid,
  output logic              Req0Ready,
  input  logic [ADDR_W-1:0] Req0Addr,
  input  logic [DATA_W-1:0] Req0Data,
  input  logic              Req1Valid,
  output logic              Req1Ready,
  input  logic [ADDR_W-1:0] Req1Addr,
  input  logic [DATA_W-1:0] Req1Data,
  output logic              WE3,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              PCWE,
  output logic [DATA_W-1:0] PCWD,
  output logic [NREG-1:0]   PendMask,
  output logic              Idle
);

  wr_req_t          buf0;
  wr_req_t          buf1;
  wr_req_t          granted;
  logic             load0;
  logic             load1;
  logic             grant0;
  logic             grant1;
  logic             commit;
  logic [AGE_W-1:0] seq;
  logic [AGE_W-1:0] age0;
  logic [AGE_W-1:0] age1;
  logic [NREG-1:0]  pend;

  // Port 1 is the earlier instruction, so on a simultaneous accept it takes the lower tag.
  assign age1 = seq;
  assign age0 = load1 ? seq + AGE_W'(1) : seq;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      seq <= '0;
    end else begin
      seq <= seq + AGE_W'(load0) + AGE_W'(load1);
    end
  end

  regfile_wr_buffer u_buf0 (
    .CLK      (CLK),
    .Reset    (Reset),
    .in_valid (Req0Valid),
    .in_age   (age0),
    .in_addr  (Req0Addr),
    .in_data  (Req0Data),
    .drain    (grant0),
    .ready    (Req0Ready),
    .load     (load0),
    .entry    (buf0)
  );

  regfile_wr_buffer u_buf1 (
    .CLK      (CLK),
    .Reset    (Reset),
    .in_valid (Req1Valid),
    .in_age   (age1),
    .in_addr  (Req1Addr),
    .in_data  (Req1Data),
    .drain    (grant1),
    .ready    (Req1Ready),
    .load     (load1),
    .entry    (buf1)
  );

  assign grant0  = buf0.valid & (~buf1.valid | is_older(buf0.age, buf1.age));
  assign grant1  = buf1.valid & ~grant0;
  assign commit  = grant0 | grant1;
  assign granted = grant0 ? buf0 : buf1;

  // Strobes last one cycle; address and data hold so the falling-edge write sees stable values.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      WE3  <= 1'b0;
      A3   <= '0;
      WD3  <= '0;
      PCWE <= 1'b0;
      PCWD <= '0;
    end else begin
      WE3  <= 1'b0;
      PCWE <= 1'b0;
      if (commit) begin
        if (granted.addr == ADDR_W'(PC_IDX)) begin
          PCWE <= 1'b1;
          PCWD <= granted.data;
        end else begin
          WE3 <= 1'b1;
          A3  <= granted.addr;
          WD3 <= granted.data;
        end
      end
    end
  end

  always_comb begin
    pend = '0;
    if (buf0.valid) pend = pend | reg_onehot(buf0.addr);
    if (buf1.valid) pend = pend | reg_onehot(buf1.addr);
    if (WE3)        pend = pend | reg_onehot(A3);
  end

  assign PendMask = pend;
  assign Idle     = ~buf0.valid & ~buf1.valid & ~WE3 & ~PCWE;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized checks of the write arbiter against an in-order expected-commit queue.
module tb_regfile_write_arbiter;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Req0Valid, Req1Valid;
  logic        Req0Ready, Req1Ready;
  logic [3:0]  Req0Addr, Req1Addr;
  logic [31:0] Req0Data, Req1Data;
  logic        WE3, PCWE, Idle;
  logic [3:0]  A3;
  logic [31:0] WD3, PCWD;
  logic [14:0] PendMask;

  int          checkCount = 0;
  int          errorCount = 0;
  logic [35:0] expQ[$];
  logic [31:0] expModel[16];
  logic [31:0] regModel[16];
  logic [31:0] expPc, pcModel;
  logic [3:0]  expLastA3;
  logic [31:0] expLastWD3;
  logic        monOn = 1'b0;
  logic        acc0, acc1;

  regfile_write_arbiter dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Req0Valid (Req0Valid),
    .Req0Ready (Req0Ready),
    .Req0Addr  (Req0Addr),
    .Req0Data  (Req0Data),
    .Req1Valid (Req1Valid),
    .Req1Ready (Req1Ready),
    .Req1Addr  (Req1Addr),
    .Req1Data  (Req1Data),
    .WE3       (WE3),
    .A3        (A3),
    .WD3       (WD3),
    .PCWE      (PCWE),
    .PCWD      (PCWD),
    .PendMask  (PendMask),
    .Idle      (Idle)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drives one cycle of requests, records what is accepted in program order, steps past the edge.
  task automatic applyStimulus(input logic v0, input logic [3:0] a0, input logic [31:0] d0,
                               input logic v1, input logic [3:0] a1, input logic [31:0] d1,
                               output logic ac0, output logic ac1);
    Req0Valid = v0; Req0Addr = a0; Req0Data = d0;
    Req1Valid = v1; Req1Addr = a1; Req1Data = d1;
    #1;
    ac0 = v0 & Req0Ready;
    ac1 = v1 & Req1Ready;
    if (ac1) begin
      expQ.push_back({a1, d1});
      if (a1 == 4'hF) expPc = d1; else expModel[a1] = d1;
    end
    if (ac0) begin
      expQ.push_back({a0, d0});
      if (a0 == 4'hF) expPc = d0; else expModel[a0] = d0;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idleCycle();
    logic x0, x1;
    applyStimulus(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, x0, x1);
  endtask

  // The register file writes on the falling edge; every commit must match the oldest expected write.
  always @(negedge CLK) begin
    if (monOn && (WE3 || PCWE)) begin
      logic [35:0] e;
      checkOutput("we3_pcwe_exclusive", 64'(WE3 & PCWE), 64'h0);
      if (expQ.size() == 0) begin
        checkOutput("spurious_commit", {28'h0, A3, WD3}, 64'h0);
      end else begin
        e = expQ.pop_front();
        if (WE3) begin
          checkOutput("commit_order", {28'h0, A3, WD3}, {28'h0, e});
          regModel[A3] = WD3;
          expLastA3  = e[35:32];
          expLastWD3 = e[31:0];
        end else begin
          checkOutput("pc_commit_order", {28'h0, 4'hF, PCWD}, {28'h0, e});
          pcModel = PCWD;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int stalls;
    int sent1;
    logic sent0;
    logic [3:0] ra0, ra1;
    logic [31:0] rd0, rd1;
    logic rv0, rv1;

    for (int i = 0; i < 16; i++) begin
      expModel[i] = '0;
      regModel[i] = '0;
    end
    expPc = '0; pcModel = '0; expLastA3 = '0; expLastWD3 = '0;
    Reset = 1'b0;
    Req0Valid = 0; Req0Addr = 0; Req0Data = 0;
    Req1Valid = 0; Req1Addr = 0; Req1Data = 0;

    // Reset state
    #3;
    checkOutput("rst_we3", 64'(WE3), 0);
    checkOutput("rst_a3", 64'(A3), 0);
    checkOutput("rst_wd3", 64'(WD3), 0);
    checkOutput("rst_pcwe", 64'(PCWE), 0);
    checkOutput("rst_pcwd", 64'(PCWD), 0);
    checkOutput("rst_pendmask", 64'(PendMask), 0);
    checkOutput("rst_idle", 64'(Idle), 1);
    checkOutput("rst_ready0", 64'(Req0Ready), 0);
    checkOutput("rst_ready1", 64'(Req1Ready), 0);
    repeat (2) @(posedge CLK);
    #3 Reset = 1'b1;
    monOn = 1'b1;
    @(posedge CLK);
    #1;
    checkOutput("ready0_after_reset", 64'(Req0Ready), 1);
    checkOutput("ready1_after_reset", 64'(Req1Ready), 1);

    // Single write R3 = 0x11
    applyStimulus(1'b1, 4'd3, 32'h11, 1'b0, 4'd0, 32'h0, acc0, acc1);
    checkOutput("t1_accept", 64'(acc0), 1);
    checkOutput("t1_we3_wait", 64'(WE3), 0);
    checkOutput("t1_pend_buffered", 64'(PendMask), 64'h0008);
    checkOutput("t1_idle_busy", 64'(Idle), 0);
    idleCycle();
    checkOutput("t1_we3", 64'(WE3), 1);
    checkOutput("t1_a3", 64'(A3), 3);
    checkOutput("t1_wd3", 64'(WD3), 64'h11);
    checkOutput("t1_pend_commit", 64'(PendMask), 64'h0008);
    idleCycle();
    checkOutput("t1_we3_pulse", 64'(WE3), 0);
    checkOutput("t1_pend_clear", 64'(PendMask), 0);
    checkOutput("t1_idle", 64'(Idle), 1);

    // Same edge, same register: port 1 commits first
    applyStimulus(1'b1, 4'd5, 32'hA, 1'b1, 4'd5, 32'hB, acc0, acc1);
    checkOutput("t2_accept_both", {62'h0, acc1, acc0}, 64'h3);
    checkOutput("t2_pend", 64'(PendMask), 64'h0020);
    checkOutput("t2_ready0_full", 64'(Req0Ready), 0);
    checkOutput("t2_ready1_drain", 64'(Req1Ready), 1);
    idleCycle();
    checkOutput("t2_first_wd3", {28'h0, A3, WD3}, {28'h0, 4'd5, 32'hB});
    checkOutput("t2_first_we3", 64'(WE3), 1);
    idleCycle();
    checkOutput("t2_second_wd3", {28'h0, A3, WD3}, {28'h0, 4'd5, 32'hA});
    idleCycle();
    checkOutput("t2_idle", 64'(Idle), 1);
    checkOutput("t2_r5_final", 64'(regModel[5]), 64'hA);

    // Port 1 streaming, port 0 interjects once
    stalls = 0; sent1 = 0; sent0 = 1'b0;
    for (int c = 0; c < 20 && (sent1 < 4 || !sent0); c++) begin
      rv1 = (sent1 < 4);
      rv0 = (c >= 1) && !sent0;
      applyStimulus(rv0, 4'd8, 32'h300, rv1, 4'd7, 32'h200 + 32'(sent1), acc0, acc1);
      if (rv1 && !acc1) stalls++;
      if (acc1) sent1++;
      if (acc0) sent0 = 1'b1;
    end
    checkOutput("t3_all_sent", {31'h0, sent0, 32'(sent1)}, {31'h0, 1'b1, 32'd4});
    checkOutput("t3_stall_le1", 64'(stalls <= 1), 1);
    for (int i = 0; i < 10 && !Idle; i++) idleCycle();
    checkOutput("t3_idle", 64'(Idle), 1);
    checkOutput("t3_r7_final", 64'(regModel[7]), 64'h203);
    checkOutput("t3_r8_final", 64'(regModel[8]), 64'h300);

    // R15 diverts to the PC strobe
    applyStimulus(1'b1, 4'd15, 32'h100, 1'b0, 4'd0, 32'h0, acc0, acc1);
    checkOutput("t4_pend_r15", 64'(PendMask), 0);
    checkOutput("t4_idle_busy", 64'(Idle), 0);
    idleCycle();
    checkOutput("t4_pcwe", 64'(PCWE), 1);
    checkOutput("t4_pcwd", 64'(PCWD), 64'h100);
    checkOutput("t4_we3", 64'(WE3), 0);
    checkOutput("t4_a3_hold", 64'(A3), 64'(expLastA3));
    checkOutput("t4_wd3_hold", 64'(WD3), 64'(expLastWD3));
    checkOutput("t4_pend", 64'(PendMask), 0);
    idleCycle();
    checkOutput("t4_pcwe_pulse", 64'(PCWE), 0);

    // Reset in the middle of a cycle with both buffers occupied
    applyStimulus(1'b1, 4'd9, 32'h55, 1'b1, 4'd10, 32'h66, acc0, acc1);
    checkOutput("t5_pend_full", 64'(PendMask), 64'h0600);
    #2;
    Reset = 1'b0;
    Req0Valid = 0; Req1Valid = 0;
    expQ.delete();
    #1;
    checkOutput("t5_we3", 64'(WE3), 0);
    checkOutput("t5_a3", 64'(A3), 0);
    checkOutput("t5_wd3", 64'(WD3), 0);
    checkOutput("t5_pend", 64'(PendMask), 0);
    checkOutput("t5_idle", 64'(Idle), 1);
    checkOutput("t5_ready", {62'h0, Req1Ready, Req0Ready}, 0);
    repeat (2) @(posedge CLK);
    #3 Reset = 1'b1;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) begin
      idleCycle();
      checkOutput("t5_no_commit", {63'h0, WE3 | PCWE}, 0);
    end
    checkOutput("t5_idle_after", 64'(Idle), 1);

    // Random dual-port traffic against program-order final values
    for (int i = 0; i < 16; i++) begin
      expModel[i] = '0;
      regModel[i] = '0;
    end
    expPc = '0; pcModel = '0;
    for (int c = 0; c < 10000; c++) begin
      rv0 = 1'($urandom_range(0, 1));
      rv1 = 1'($urandom_range(0, 1));
      ra0 = 4'($urandom_range(0, 15));
      ra1 = 4'($urandom_range(0, 15));
      rd0 = $urandom;
      rd1 = $urandom;
      applyStimulus(rv0, ra0, rd0, rv1, ra1, rd1, acc0, acc1);
    end
    for (int i = 0; i < 10 && !Idle; i++) idleCycle();
    checkOutput("t6_idle", 64'(Idle), 1);
    checkOutput("t6_queue_empty", 64'(expQ.size()), 0);
    for (int r = 0; r < 15; r++) begin
      checkOutput($sformatf("t6_r%0d_final", r), 64'(regModel[r]), 64'(expModel[r]));
    end
    checkOutput("t6_pc_final", 64'(pcModel), 64'(expPc));

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
